cas_fsk_tx: RTL and testbench

Cassette output encoder for the MSX core: takes bytes from the tape-save path over a valid/ready handshake and produces the MSX 1200-baud FSK square wave on a 1-bit level output. It is the transmit-side counterpart of the EAR/ADC tape input path. The same wave is routed to the audio mixer and to the user-port CMT-out pin. It generates both the long and short leader (header) tones and frames each byte as 1 start bit, 8 data bits LSB first, and 2 stop bits.

---
 rtl/cas_fsk_tx.sv | 210 +++++++++++++++++++++
 tb/tb_cas_fsk_tx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cas_fsk_tx.sv
// Purpose: MSX cassette-out encoder that turns bytes and header requests into a
//          1200-baud FSK square wave on cas_out.
// Latency: cas_out rises on the first cycle after the accept edge; there is no added latency.
// Backpressure: din_ready is combinational: (state==IDLE) & ~hdr_req. It stays low for the
//          whole header or frame. A held din_valid gets one IDLE cycle between frames.
//
// Ports:
//   clk_sys            system clock (the only clock)
//   reset_n            asynchronous active-low reset
//   hdr_req/hdr_long   one-cycle header request and length select (1 = LONG_HDR), sampled in IDLE
//   din/din_valid      byte to send and its valid strobe
//   din_ready          byte accepted on an edge where din_valid & din_ready
//   abort              synchronous kill; returns to IDLE on the next edge, ahead of every other input
//   cas_out            registered FSK level
//   busy               registered, high whenever the encoder is not IDLE
//
// Bit encoding: '0' = one slow pulse (HALF_SLOW high + HALF_SLOW low).
// '1' = two fast pulses (HALF_FAST high + HALF_FAST low, twice).
// Both bit types last 4*HALF_FAST cycles. A frame is start(0), 8 data bits LSB first, then two stop(1) bits.

module cas_fsk_tx #(
    parameter int CLK_HZ    = 21477270,
    parameter int BAUD      = 1200,
    parameter int LONG_HDR  = 16000,
    parameter int SHORT_HDR = 4000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       hdr_req,
    input  logic       hdr_long,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic       abort,
    output logic       cas_out,
    output logic       busy
);

    localparam int HALF_FAST = CLK_HZ / (BAUD * 4);
    localparam int HALF_SLOW = 2 * HALF_FAST;
    // The half-period counter only ever has to reach HALF_SLOW-1.
    localparam int CW        = (HALF_SLOW > 2) ? $clog2(HALF_SLOW) : 1;

    localparam logic [CW-1:0] FAST_LAST = CW'(HALF_FAST - 1);
    localparam logic [CW-1:0] SLOW_LAST = CW'(HALF_SLOW - 1);
    localparam logic [13:0]   LONG_CNT  = 14'(LONG_HDR);
    localparam logic [13:0]   SHORT_CNT = 14'(SHORT_HDR);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t          state;
    logic [CW-1:0]   hcnt;        // cycles elapsed in the current half period
    logic            low_half;    // 0 = high half of the pulse, 1 = low half
    logic            slow;        // current pulse uses HALF_SLOW
    logic            more;        // a '1' bit still owes its second fast pulse
    logic [13:0]     hdr_cnt;     // header pulses left, including the current one
    logic [2:0]      bit_idx;     // data bit currently on the wire
    logic            stop_second; // second stop bit is on the wire
    logic [7:0]      shift;       // remaining data bits; bit 0 is the next one sent

    logic            half_last;

    // The last cycle of a half period depends on the speed of the current pulse.
    always_comb begin
        half_last = (hcnt == (slow ? SLOW_LAST : FAST_LAST));
    end

    always_comb begin
        din_ready = (state == IDLE) & ~hdr_req;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            hcnt        <= '0;
            low_half    <= 1'b0;
            slow        <= 1'b0;
            more        <= 1'b0;
            hdr_cnt     <= '0;
            bit_idx     <= '0;
            stop_second <= 1'b0;
            shift       <= '0;
            cas_out     <= 1'b0;
            busy        <= 1'b0;
        end else if (abort) begin
            // Discards any latched byte. An acceptance on this same edge is
            // still counted as consumed upstream because din_ready ignores abort.
            state       <= IDLE;
            hcnt        <= '0;
            low_half    <= 1'b0;
            slow        <= 1'b0;
            more        <= 1'b0;
            hdr_cnt     <= '0;
            bit_idx     <= '0;
            stop_second <= 1'b0;
            shift       <= '0;
            cas_out     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cas_out  <= 1'b0;
                    busy     <= 1'b0;
                    hcnt     <= '0;
                    low_half <= 1'b0;
                    if (hdr_req) begin
                        // The header wins over a simultaneous byte. din_ready
                        // is low here, so that byte stays with the sender.
                        state   <= HDR;
                        busy    <= 1'b1;
                        cas_out <= 1'b1;
                        slow    <= 1'b0;
                        more    <= 1'b0;
                        hdr_cnt <= hdr_long ? LONG_CNT : SHORT_CNT;
                    end else if (din_valid) begin
                        // The start bit is a '0': one slow pulse.
                        shift       <= din;
                        state       <= START;
                        busy        <= 1'b1;
                        cas_out     <= 1'b1;
                        slow        <= 1'b1;
                        more        <= 1'b0;
                        bit_idx     <= '0;
                        stop_second <= 1'b0;
                    end
                end

                default: begin
                    if (!half_last) begin
                        hcnt <= hcnt + CW'(1);
                    end else begin
                        hcnt <= '0;
                        if (!low_half) begin
                            low_half <= 1'b1;
                            cas_out  <= 1'b0;
                        end else begin
                            // A pulse has just finished. By default the next
                            // pulse starts high now; the cases below only pick
                            // its speed or send the encoder back to IDLE.
                            low_half <= 1'b0;
                            cas_out  <= 1'b1;
                            if (state == HDR) begin
                                // A loaded count of 0 behaves like 1.
                                if (hdr_cnt < 14'd2) begin
                                    state   <= IDLE;
                                    busy    <= 1'b0;
                                    cas_out <= 1'b0;
                                    hdr_cnt <= '0;
                                end else begin
                                    hdr_cnt <= hdr_cnt - 14'd1;
                                end
                            end else if (more) begin
                                // Second fast pulse of a '1' bit.
                                more <= 1'b0;
                            end else begin
                                // The bit is complete; set up the next one.
                                case (state)
                                    START: begin
                                        state   <= DATA;
                                        bit_idx <= '0;
                                        slow    <= ~shift[0];
                                        more    <= shift[0];
                                    end
                                    DATA: begin
                                        shift <= {1'b0, shift[7:1]};
                                        if (bit_idx == 3'd7) begin
                                            state       <= STOP;
                                            stop_second <= 1'b0;
                                            slow        <= 1'b0;
                                            more        <= 1'b1;
                                        end else begin
                                            bit_idx <= bit_idx + 3'd1;
                                            slow    <= ~shift[1];
                                            more    <= shift[1];
                                        end
                                    end
                                    STOP: begin
                                        if (stop_second) begin
                                            state       <= IDLE;
                                            busy        <= 1'b0;
                                            cas_out     <= 1'b0;
                                            stop_second <= 1'b0;
                                            slow        <= 1'b0;
                                        end else begin
                                            stop_second <= 1'b1;
                                            slow        <= 1'b0;
                                            more        <= 1'b1;
                                        end
                                    end
                                    default: begin
                                        state   <= IDLE;
                                        busy    <= 1'b0;
                                        cas_out <= 1'b0;
                                    end
                                endcase
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cas_fsk_tx.sv
// Purpose: directed self-checking bench for cas_fsk_tx at CLK_HZ=48000, BAUD=1200.
// Latency: HALF_FAST=10, bit=40 cycles, frame=440 cycles; the header uses 20 cycles per pulse.
// Backpressure: din_ready is checked low for the whole header or frame, and high in IDLE.
//
// Ports: drives every input of cas_fsk_tx. It samples outputs 1 time unit after each
// rising edge and drives inputs at that same point.

module tb_cas_fsk_tx;

    logic       clk_sys;
    logic       reset_n;
    logic       hdr_req;
    logic       hdr_long;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       abort;
    logic       cas_out;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic wave [2048];

    cas_fsk_tx #(
        .CLK_HZ   (48000),
        .BAUD     (1200),
        .LONG_HDR (7),
        .SHORT_HDR(5)
    ) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .hdr_req  (hdr_req),
        .hdr_long (hdr_long),
        .din      (din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .abort    (abort),
        .cas_out  (cas_out),
        .busy     (busy)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (observed running, required done)");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Record cas_out while busy is high, with a bounded number of cycles.
    // It returns on the first sample where busy is low.
    task automatic run_busy(output int n, output int rdy_hi);
        n = 0;
        rdy_hi = 0;
        while (busy === 1'b1 && n < 2048) begin
            wave[n] = cas_out;
            if (din_ready !== 1'b0) rdy_hi++;
            n++;
            step();
        end
    endtask

    // Decode the recorded wave by run length.
    // 20 high + 20 low is a '0' bit; two 10/10 pulses make a '1' bit.
    task automatic decode(input int n, output logic [15:0] bits, output int nbits,
                          output int nfast, output int nodd);
        int i;
        int h;
        int l;
        int pend;
        bits = '0; nbits = 0; nfast = 0; nodd = 0; pend = 0; i = 0;
        while (i < n) begin
            h = 0;
            while (i < n && wave[i] === 1'b1) begin h++; i++; end
            l = 0;
            while (i < n && wave[i] === 1'b0) begin l++; i++; end
            if (h == 20 && l == 20 && pend == 0) begin
                if (nbits < 16) bits[nbits] = 1'b0;
                nbits++;
            end else if (h == 10 && l == 10) begin
                nfast++;
                if (pend == 1) begin
                    if (nbits < 16) bits[nbits] = 1'b1;
                    nbits++;
                    pend = 0;
                end else begin
                    pend = 1;
                end
            end else begin
                nodd++;
            end
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        return {2'b11, b, 1'b0};
    endfunction

    // Check a full frame that is already in flight.
    // Call it on the first sample after the accept edge.
    task automatic check_frame(input string tag, input logic [10:0] exp_bits);
        int n, rdy_hi, nbits, nfast, nodd;
        logic [15:0] bits;
        run_busy(n, rdy_hi);
        decode(n, bits, nbits, nfast, nodd);
        chk({tag, "_busy_len"}, n, 440);
        chk({tag, "_nbits"}, nbits, 11);
        chk({tag, "_bits"}, {21'd0, bits[10:0]}, {21'd0, exp_bits});
        chk({tag, "_odd_runs"}, nodd, 0);
        chk({tag, "_rdy_during"}, rdy_hi, 0);
        chk({tag, "_cas_after"}, cas_out, 0);
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b);
        din = b;
        din_valid = 1'b1;
        #1;
        chk({tag, "_rdy_idle"}, din_ready, 1);
        step();
        din_valid = 1'b0;
        chk({tag, "_busy_rise"}, busy, 1);
        chk({tag, "_cas_rise"}, cas_out, 1);
    endtask

    initial begin
        int n, rdy_hi, nbits, nfast, nodd;
        logic [15:0] bits;

        reset_n = 1'b0; hdr_req = 1'b0; hdr_long = 1'b0;
        din = 8'h00; din_valid = 1'b0; abort = 1'b0;
        repeat (3) step();
        chk("rst_cas", cas_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdy", din_ready, 1);
        reset_n = 1'b1;
        step();

        // 1: byte 0x00 gives 9 slow pulses, then 4 fast pulses.
        send_byte("b00", 8'h00);
        run_busy(n, rdy_hi);
        decode(n, bits, nbits, nfast, nodd);
        chk("b00_busy_len", n, 440);
        chk("b00_bits", {21'd0, bits[10:0]}, {21'd0, 11'b110_0000_0000});
        chk("b00_fast_pulses", nfast, 4);
        chk("b00_odd_runs", nodd, 0);
        chk("b00_rdy_during", rdy_hi, 0);
        chk("b00_busy_after", busy, 0);

        // 2: byte 0xA5 decodes as 0,1,0,1,0,0,1,0,1,1,1.
        step();
        send_byte("bA5", 8'hA5);
        check_frame("bA5", 11'b111_0100_1010);

        // 3: short header (5 pulses), then long header (7 pulses).
        step();
        hdr_req = 1'b1; hdr_long = 1'b0;
        step();
        hdr_req = 1'b0;
        run_busy(n, rdy_hi);
        decode(n, bits, nbits, nfast, nodd);
        chk("shdr_busy_len", n, 100);
        chk("shdr_pulses", nfast, 5);
        chk("shdr_odd_runs", nodd, 0);
        chk("shdr_cas_after", cas_out, 0);
        step();
        chk("shdr_cas_idle", cas_out, 0);
        hdr_req = 1'b1; hdr_long = 1'b1;
        step();
        hdr_req = 1'b0; hdr_long = 1'b0;
        run_busy(n, rdy_hi);
        decode(n, bits, nbits, nfast, nodd);
        chk("lhdr_busy_len", n, 140);
        chk("lhdr_pulses", nfast, 7);

        // 4: header and byte requested together; the header goes first.
        step();
        hdr_req = 1'b1; hdr_long = 1'b0; din = 8'h3C; din_valid = 1'b1;
        #1;
        chk("coll_rdy", din_ready, 0);
        step();
        hdr_req = 1'b0;
        run_busy(n, rdy_hi);
        decode(n, bits, nbits, nfast, nodd);
        chk("coll_hdr_len", n, 100);
        chk("coll_hdr_pulses", nfast, 5);
        chk("coll_rdy_during", rdy_hi, 0);
        chk("coll_rdy_after", din_ready, 1);
        step();
        din_valid = 1'b0;
        chk("coll_byte_start", busy, 1);
        check_frame("coll_b3C", frame_bits(8'h3C));

        // 5: 0xFF then 0x00 back to back, separated by exactly one IDLE cycle.
        step();
        din = 8'hFF; din_valid = 1'b1;
        step();
        din = 8'h00;
        run_busy(n, rdy_hi);
        decode(n, bits, nbits, nfast, nodd);
        chk("b2b_ff_len", n, 440);
        chk("b2b_ff_bits", {21'd0, bits[10:0]}, {21'd0, 11'b111_1111_1110});
        chk("b2b_gap_busy", busy, 0);
        chk("b2b_gap_cas", cas_out, 0);
        chk("b2b_gap_rdy", din_ready, 1);
        step();
        din_valid = 1'b0;
        chk("b2b_second_busy", busy, 1);
        check_frame("b2b_00", frame_bits(8'h00));

        // abort on the same edge as an acceptance: the encoder stays IDLE.
        step();
        din = 8'h77; din_valid = 1'b1; abort = 1'b1;
        #1;
        chk("abacc_rdy", din_ready, 1);
        step();
        din_valid = 1'b0; abort = 1'b0;
        chk("abacc_busy", busy, 0);
        step();
        chk("abacc_busy_later", busy, 0);

        // 6a: abort mid-DATA at cycle 150, then send a fresh byte.
        send_byte("ab", 8'hC3);
        repeat (149) step();
        chk("ab_busy_150", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_cas", cas_out, 0);
        step();
        send_byte("ab_fresh", 8'h5A);
        check_frame("ab_fresh", frame_bits(8'h5A));

        // 6b: reset mid-header clears the outputs asynchronously.
        step();
        hdr_req = 1'b1; hdr_long = 1'b1;
        step();
        hdr_req = 1'b0; hdr_long = 1'b0;
        repeat (30) step();
        chk("rh_busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("rh_busy_async", busy, 0);
        chk("rh_cas_async", cas_out, 0);
        #2;
        reset_n = 1'b1;
        step();
        chk("rh_busy_idle", busy, 0);
        send_byte("rh_fresh", 8'h81);
        check_frame("rh_fresh", frame_bits(8'h81));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
